// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO, with pipeline stall
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inStart,
  input  logic [1:0]       inOp,
  input  logic [WIDTH-1:0] inOpA,
  input  logic [WIDTH-1:0] inOpB,
  input  logic             inEX_Flush,
  input  logic             inMfReq,
  input  logic             inWriteHi,
  input  logic             inWriteLo,
  input  logic [WIDTH-1:0] inData,
  output logic [WIDTH-1:0] outHi,
  output logic [WIDTH-1:0] outLo,
  output logic             outBusy,
  output logic             outStall,
  output logic             outDone,
  output logic             outDivZero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;
  state_t             state;
  logic [1:0]         op;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg_q, neg_r;
  logic               accept, is_div, is_signed;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  always_comb begin
    accept    = state == IDLE && inStart && !inEX_Flush;
    is_div    = op[1];
    is_signed = !op[0];
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (op_b[0] ? {1'b0, op_a} : '0);
    rem_sh    = {acc[2*WIDTH-1:WIDTH], op_a[WIDTH-1]};
    diff      = rem_sh - {1'b0, op_b};
    prod      = neg_q ? -acc : acc;
    quo       = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem       = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  assign outBusy  = state != IDLE;
  assign outStall = outBusy && (inStart || inMfReq || inWriteHi || inWriteLo);
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      cnt        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      outHi      <= '0;
      outLo      <= '0;
      outDone    <= 1'b0;
      outDivZero <= 1'b0;
    end else begin
      outDone <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op    <= inOp;
            op_a  <= inOpA;
            op_b  <= inOpB;
            state <= PREP;
          end else begin
            if (inWriteHi) outHi <= inData;
            if (inWriteLo) outLo <= inData;
          end
        end
        PREP: begin
          op_a  <= (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
          op_b  <= (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
          neg_q <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          neg_r <= is_signed && op_a[WIDTH-1];
          acc   <= '0;
          cnt   <= '0;
          if (is_div) outDivZero <= op_b == '0;
          state <= CALC;
        end
        CALC: begin
          if (is_div) begin
            acc  <= {diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], !diff[WIDTH]};
            op_a <= op_a << 1;
          end else begin
            acc  <= {mul_sum, acc[WIDTH-1:1]};
            op_b <= op_b >> 1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        default: begin
          outHi   <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
          outLo   <= is_div ? (outDivZero ? '1 : quo) : prod[WIDTH-1:0];
          outDone <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed checks of muldiv_sequencer against an arithmetic model
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset, inStart, inEX_Flush, inMfReq, inWriteHi, inWriteLo;
  logic [1:0] inOp;
  logic [31:0] inOpA, inOpB, inData, outHi, outLo;
  logic outBusy, outStall, outDone, outDivZero;
  int total = 0, bad = 0;
  int busy_seen, stall_seen, done_seen;
  int m_left = 0;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic m_dz, p_dz, p_div, m_done;
  logic m_valid = 1'b0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .inStart(inStart), .inOp(inOp), .inOpA(inOpA), .inOpB(inOpB),
    .inEX_Flush(inEX_Flush), .inMfReq(inMfReq), .inWriteHi(inWriteHi), .inWriteLo(inWriteLo),
    .inData(inData), .outHi(outHi), .outLo(outLo), .outBusy(outBusy), .outStall(outStall),
    .outDone(outDone), .outDivZero(outDivZero)
  );

  function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (op == 2'd0) begin
      r = 64'(sa * sb);
      return {1'b0, r};
    end
    if (op == 2'd1) begin
      r = 64'(ua * ub);
      return {1'b0, r};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
    if (op == 2'd2) return {1'b0, 32'(sa % sb), 32'(sa / sb)};
    return {1'b0, 32'(ua % ub), 32'(ua / ub)};
  endfunction

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clr();
    reset = 1'b0; inStart = 1'b0; inOp = 2'd0; inOpA = 32'd0; inOpB = 32'd0; inEX_Flush = 1'b0;
    inMfReq = 1'b0; inWriteHi = 1'b0; inWriteLo = 1'b0; inData = 32'd0;
  endtask

  task automatic step();
    @(negedge clk);
    if (m_valid) begin
      chk("busy", 65'(outBusy), 65'(m_left > 0));
      chk("hi", 65'(outHi), 65'(m_hi));
      chk("lo", 65'(outLo), 65'(m_lo));
      chk("done", 65'(outDone), 65'(m_done));
      chk("divzero", 65'(outDivZero), 65'(m_dz));
      chk("stall", 65'(outStall), 65'(m_left > 0 && (inStart || inMfReq || inWriteHi || inWriteLo)));
      if (outBusy) busy_seen++;
      if (outStall) stall_seen++;
      if (outDone) done_seen++;
    end
    if (reset) begin
      m_valid = 1'b1; m_left = 0; m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (m_left == 34 && p_div) m_dz = p_dz;
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (inStart && !inEX_Flush) begin
        {p_dz, p_hi, p_lo} = ref_op(inOp, inOpA, inOpB);
        p_div = inOp[1];
        m_left = 34;
      end else begin
        if (inWriteHi) m_hi = inData;
        if (inWriteLo) m_lo = inData;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int mf_from, input int start2_at);
    clr();
    inStart = 1'b1; inOp = op; inOpA = a; inOpB = b;
    step();
    clr();
    busy_seen = 0; stall_seen = 0; done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      inMfReq = i >= mf_from;
      inStart = i == start2_at;
      inOp = 2'd3; inOpA = 32'd9; inOpB = 32'd3;
      step();
    end
    clr();
  endtask

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    chk("rst_hi", 65'(outHi), 65'd0);
    chk("rst_lo", 65'(outLo), 65'd0);
    chk("rst_busy", 65'(outBusy), 65'd0);
    chk("rst_done", 65'(outDone), 65'd0);
    chk("rst_dz", 65'(outDivZero), 65'd0);
    clr();
    step();

    chk("ref_mult", ref_op(2'd0, 32'hFFFFFFFD, 32'd7), {1'b0, 64'hFFFFFFFF_FFFFFFEB});
    chk("ref_multu", ref_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF), {1'b0, 64'hFFFFFFFE_00000001});
    chk("ref_div", ref_op(2'd2, 32'hFFFFFFF9, 32'd2), {1'b0, 64'hFFFFFFFF_FFFFFFFD});
    chk("ref_divovf", ref_op(2'd2, 32'h80000000, 32'hFFFFFFFF), {1'b0, 64'h00000000_80000000});
    chk("ref_divu0", ref_op(2'd3, 32'd100, 32'd0), {1'b1, 64'h00000064_FFFFFFFF});

    run_op(2'd0, 32'hFFFFFFFD, 32'd7, 99, 99);
    chk("mult_hi", 65'(outHi), 65'h0FFFFFFFF);
    chk("mult_lo", 65'(outLo), 65'h0FFFFFFEB);
    chk("mult_busy_len", 65'(busy_seen), 65'd34);
    chk("mult_done_cnt", 65'(done_seen), 65'd1);

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 99, 99);
    chk("multu_hi", 65'(outHi), 65'h0FFFFFFFE);
    chk("multu_lo", 65'(outLo), 65'h000000001);

    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 99, 99);
    chk("div_hi", 65'(outHi), 65'h0FFFFFFFF);
    chk("div_lo", 65'(outLo), 65'h0FFFFFFFD);

    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 99, 99);
    chk("divovf_hi", 65'(outHi), 65'd0);
    chk("divovf_lo", 65'(outLo), 65'h080000000);
    chk("divovf_dz", 65'(outDivZero), 65'd0);

    run_op(2'd3, 32'd100, 32'd0, 99, 99);
    chk("divu0_hi", 65'(outHi), 65'h000000064);
    chk("divu0_lo", 65'(outLo), 65'h0FFFFFFFF);
    chk("divu0_dz", 65'(outDivZero), 65'd1);
    inWriteLo = 1'b1; inData = 32'h12345678;
    step();
    clr();
    step();
    chk("mtlo_lo", 65'(outLo), 65'h012345678);
    chk("mtlo_dz", 65'(outDivZero), 65'd1);

    inStart = 1'b1; inEX_Flush = 1'b1; inOp = 2'd1; inOpA = 32'd5; inOpB = 32'd5;
    step();
    clr();
    step();
    chk("flush_busy", 65'(outBusy), 65'd0);
    chk("flush_hi", 65'(outHi), 65'h000000064);
    chk("flush_lo", 65'(outLo), 65'h012345678);

    run_op(2'd1, 32'd6, 32'd7, 4, 9);
    chk("stall_len", 65'(stall_seen), 65'd30);
    chk("stall_busy_len", 65'(busy_seen), 65'd34);
    chk("stall_lo", 65'(outLo), 65'd42);
    chk("stall_hi", 65'(outHi), 65'd0);

    inStart = 1'b1; inOp = 2'd0; inOpA = 32'd11; inOpB = 32'd13;
    step();
    clr();
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", 65'(outBusy), 65'd0);
    chk("abort_hi", 65'(outHi), 65'd0);
    chk("abort_lo", 65'(outLo), 65'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) step();
    chk("abort_no_done", 65'(done_seen), 65'd0);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 500) == 0;
      inStart = ($urandom % 6) == 0;
      inOp = 2'($urandom);
      case ($urandom % 8)
        0: inOpA = 32'd0;
        1: inOpA = 32'hFFFFFFFF;
        2: inOpA = 32'h80000000;
        default: inOpA = $urandom;
      endcase
      case ($urandom % 8)
        0: inOpB = 32'd0;
        1: inOpB = 32'hFFFFFFFF;
        2: inOpB = 32'd1;
        default: inOpB = $urandom;
      endcase
      inEX_Flush = ($urandom % 4) == 0;
      inMfReq = ($urandom % 3) == 0;
      inWriteHi = ($urandom % 8) == 0;
      inWriteLo = ($urandom % 8) == 0;
      inData = $urandom;
      step();
    end
    clr();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
